weight_stream_controller: RTL and testbench

WEIGHT_STREAM_CONTROLLER -- requirements
Module: weight_stream_controller

---
 rtl/weight_stream_controller_pkg.sv | 25 ++
 rtl/weight_stream_controller_lane_delay.sv | 50 +++++
 rtl/weight_stream_controller.sv | 188 ++++++++++++++++++
 tb/tb_weight_stream_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_controller_pkg.sv
// Shared definitions for the weight stream controller.
//   - FSM state encoding
//   - default parameter constants
//   - signed tile element type
package weight_stream_controller_pkg;

  localparam int unsigned DEF_NUM_LANES = 2;
  localparam int unsigned DEF_TILE      = 6;
  localparam int unsigned DEF_EW        = 12;
  localparam int unsigned DEF_AW        = 8;
  localparam int unsigned DEF_SRAM_LAT  = 1;
  localparam int unsigned DEF_LANE_SKEW = 1;

  // Width of one packed memory word per lane.
  localparam int unsigned MEM_W = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } wsc_state_e;

  typedef logic signed [DEF_EW-1:0] tile_elem_t;

endpackage

// File: rtl/weight_stream_controller_lane_delay.sv
// weight_lane_delay: per-lane output register plus skew delay line.
//   clk, reset      : clock, asynchronous active-low reset
//   valid_i/tile_i/od_i : tile data with its od tag, as returned by memory
//   valid_o/tile_o/od_o : same, delayed by DEPTH cycles (DEPTH >= 1)
// All three fields shift together so they stay aligned at the output.
module weight_lane_delay
  import weight_stream_controller_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned TW    = 432,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  input  logic [TW-1:0] tile_i,
  input  logic [AW-1:0] od_i,
  output logic          valid_o,
  output logic [TW-1:0] tile_o,
  output logic [AW-1:0] od_o
);

  logic [DEPTH-1:0] valid_q;
  logic [TW-1:0]    tile_q [DEPTH];
  logic [AW-1:0]    od_q   [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tile_q[i] <= '0;
        od_q[i]   <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      tile_q[0]  <= tile_i;
      od_q[0]    <= od_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        tile_q[i]  <= tile_q[i-1];
        od_q[i]    <= od_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign tile_o  = tile_q[DEPTH-1];
  assign od_o    = od_q[DEPTH-1];

endmodule

// File: rtl/weight_stream_controller.sv
// weight_stream_controller: streams weight tiles for a job of od_count output
// channels from memory, NUM_LANES consecutive ods per issue cycle.
//   clk, reset            : clock, asynchronous active-low reset
//   total_od_i, id_i      : address offset = total_od * id (mod 2^AW)
//   start_i, od_base_i, od_count_i : job start and od range
//   pe_ready_i            : issue permission (stall when 0)
//   busy_o, done_o        : job active, one-cycle completion pulse
//   mem_addr_o/mem_req_o  : per-lane read address and strobe
//   mem_data_i/mem_valid_i: per-lane read data (512b packed) and valid
//   tile_o/tile_valid_o/tile_od_o : per-lane unpacked tile, valid, od tag;
//                           lane k lags memory by 1 + k*LANE_SKEW cycles
module weight_stream_controller
  import weight_stream_controller_pkg::*;
#(
  parameter int unsigned NUM_LANES = DEF_NUM_LANES,
  parameter int unsigned TILE      = DEF_TILE,
  parameter int unsigned EW        = DEF_EW,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned SRAM_LAT  = DEF_SRAM_LAT,
  parameter int unsigned LANE_SKEW = DEF_LANE_SKEW
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [AW-1:0]                    total_od_i,
  input  logic                             start_i,
  input  logic [AW-1:0]                    od_base_i,
  input  logic [3:0]                       id_i,
  input  logic [AW-1:0]                    od_count_i,
  input  logic                             pe_ready_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [NUM_LANES*AW-1:0]          mem_addr_o,
  output logic [NUM_LANES-1:0]             mem_req_o,
  input  logic [NUM_LANES*MEM_W-1:0]       mem_data_i,
  input  logic [NUM_LANES-1:0]             mem_valid_i,
  output logic [NUM_LANES*TILE*TILE*EW-1:0] tile_o,
  output logic [NUM_LANES-1:0]             tile_valid_o,
  output logic [NUM_LANES*AW-1:0]          tile_od_o
);

  localparam int unsigned TW = TILE * TILE * EW;
  localparam int unsigned CW = 16;

  wsc_state_e        state_q, state_d;
  logic [AW+1:0]     od_q, od_d;       // current group base (headroom past end)
  logic [AW:0]       end_q, end_d;     // od_base + od_count
  logic [AW-1:0]     off_q, off_d;     // total_od * id, already truncated
  logic [CW-1:0]     cnt_q, cnt_d;     // outstanding tiles
  logic              issue;
  logic [AW+3:0]     prod;
  logic [NUM_LANES*AW-1:0] issue_od;

  // Only the truncated product is ever used, so it is latched instead of
  // total_od and id separately.
  assign prod = {4'b0000, total_od_i} * {{AW{1'b0}}, id_i};

  always_comb begin
    state_d = state_q;
    od_d    = od_q;
    end_d   = end_q;
    off_d   = off_q;
    issue   = 1'b0;
    done_o  = 1'b0;
    busy_o  = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          od_d    = {2'b00, od_base_i};
          end_d   = {1'b0, od_base_i} + {1'b0, od_count_i};
          off_d   = prod[AW-1:0];
          state_d = (od_count_i == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (pe_ready_i) begin
          issue = 1'b1;
          od_d  = od_q + (AW+2)'(NUM_LANES);
          if (od_d >= {1'b0, end_q}) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic [AW+1:0] lane_od;
    lane_od    = '0;
    mem_addr_o = '0;
    mem_req_o  = '0;
    issue_od   = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      lane_od                = od_q + (AW+2)'(k);
      issue_od[k*AW +: AW]   = lane_od[AW-1:0];
      mem_addr_o[k*AW +: AW] = lane_od[AW-1:0] + off_q;
      mem_req_o[k]           = issue && (lane_od < {1'b0, end_q});
    end
  end

  // Stray returns (no matching request) may decrement below zero; clamp.
  always_comb begin
    logic [CW-1:0] inc, dec, sum;
    inc = '0;
    dec = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      inc = inc + CW'(mem_req_o[k]);
      dec = dec + CW'(tile_valid_o[k]);
    end
    sum   = cnt_q + inc;
    cnt_d = (sum < dec) ? '0 : (sum - dec);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      od_q    <= '0;
      end_q   <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      od_q    <= od_d;
      end_q   <= end_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  // od tag pipeline, SRAM_LAT deep so the tag lines up with mem_valid_i.
  logic [AW-1:0]       tag_q   [NUM_LANES][SRAM_LAT];
  logic [SRAM_LAT-1:0] tag_v_q [NUM_LANES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        tag_v_q[k] <= '0;
        for (int unsigned s = 0; s < SRAM_LAT; s++) tag_q[k][s] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        tag_q[k][0]   <= issue_od[k*AW +: AW];
        tag_v_q[k][0] <= mem_req_o[k];
        for (int unsigned s = 1; s < SRAM_LAT; s++) begin
          tag_q[k][s]   <= tag_q[k][s-1];
          tag_v_q[k][s] <= tag_v_q[k][s-1];
        end
      end
    end
  end

  // Element [i][j] sits at bit (i*TILE+j)*EW of the memory word, so the
  // unpacked tile is the contiguous low TW bits of each lane's word.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [AW-1:0] tag_at_mem;
    // Unrequested returns carry tag 0.
    assign tag_at_mem = tag_v_q[k][SRAM_LAT-1] ? tag_q[k][SRAM_LAT-1] : '0;

    weight_lane_delay #(
      .DEPTH (1 + k * LANE_SKEW),
      .TW    (TW),
      .AW    (AW)
    ) u_delay (
      .clk     (clk),
      .reset   (reset),
      .valid_i (mem_valid_i[k]),
      .tile_i  (mem_data_i[k*MEM_W +: TW]),
      .od_i    (tag_at_mem),
      .valid_o (tile_valid_o[k]),
      .tile_o  (tile_o[k*TW +: TW]),
      .od_o    (tile_od_o[k*AW +: AW])
    );
  end

  if (TW < MEM_W) begin : g_unused
    logic unused_hi;
    always_comb begin
      unused_hi = 1'b0;
      for (int unsigned k = 0; k < NUM_LANES; k++)
        unused_hi = unused_hi ^ (^mem_data_i[k*MEM_W+TW +: MEM_W-TW]);
    end
  end

endmodule

// File: tb/tb_weight_stream_controller.sv
module tb_weight_stream_controller;
  localparam int TW = 432;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] total_od, od_base, od_count;
  logic [3:0] id;
  logic       start2, start4, pe_ready, sel;
  logic [1:0] inj2;

  logic busy2, done2;
  logic [15:0] addr2, od2;
  logic [1:0]  req2, mval2, mv2_in, tv2;
  logic [1023:0] mdata2;
  logic [863:0]  tile2;

  logic busy4, done4;
  logic [31:0] addr4, od4;
  logic [3:0]  req4, mval4, tv4;
  logic [2047:0] mdata4;
  logic [1727:0] tile4;

  logic [511:0] mem [256];

  weight_stream_controller dut2 (
    .clk(clk), .reset(reset), .total_od_i(total_od), .start_i(start2),
    .od_base_i(od_base), .id_i(id), .od_count_i(od_count), .pe_ready_i(pe_ready),
    .busy_o(busy2), .done_o(done2), .mem_addr_o(addr2), .mem_req_o(req2),
    .mem_data_i(mdata2), .mem_valid_i(mv2_in), .tile_o(tile2),
    .tile_valid_o(tv2), .tile_od_o(od2));

  weight_stream_controller #(.NUM_LANES(4), .LANE_SKEW(2)) dut4 (
    .clk(clk), .reset(reset), .total_od_i(total_od), .start_i(start4),
    .od_base_i(od_base), .id_i(id), .od_count_i(od_count), .pe_ready_i(pe_ready),
    .busy_o(busy4), .done_o(done4), .mem_addr_o(addr4), .mem_req_o(req4),
    .mem_data_i(mdata4), .mem_valid_i(mval4), .tile_o(tile4),
    .tile_valid_o(tv4), .tile_od_o(od4));

  // Latency-1 memories.
  assign mv2_in = mval2 | inj2;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mval2[k] <= req2[k];
      mdata2[k*512 +: 512] <= mem[addr2[k*8 +: 8]];
    end
    for (int k = 0; k < 4; k++) begin
      mval4[k] <= req4[k];
      mdata4[k*512 +: 512] <= mem[addr4[k*8 +: 8]];
    end
  end

  // Unified view of the selected DUT.
  logic [3:0]    v_req, v_tv;
  logic [7:0]    v_addr [4];
  logic [7:0]    v_od   [4];
  logic [TW-1:0] v_tile [4];
  logic          v_done, v_busy;
  always_comb begin
    v_req  = '0;
    v_tv   = '0;
    v_done = sel ? done4 : done2;
    v_busy = sel ? busy4 : busy2;
    for (int k = 0; k < 4; k++) begin
      v_addr[k] = '0; v_od[k] = '0; v_tile[k] = '0;
      if (sel) begin
        v_req[k] = req4[k]; v_tv[k] = tv4[k];
        v_addr[k] = addr4[k*8 +: 8]; v_od[k] = od4[k*8 +: 8]; v_tile[k] = tile4[k*TW +: TW];
      end else if (k < 2) begin
        v_req[k] = req2[k]; v_tv[k] = tv2[k];
        v_addr[k] = addr2[k*8 +: 8]; v_od[k] = od2[k*8 +: 8]; v_tile[k] = tile2[k*TW +: TW];
      end
    end
  end

  typedef struct { logic [7:0] tag; logic [7:0] addr; int due; } exp_t;
  exp_t sb [4][$];
  int checks = 0;
  int errors = 0;

  // Reference unpack: element [i][j] is 12 signed bits at (i*6+j)*12.
  function automatic logic [TW-1:0] ref_tile(input logic [7:0] a);
    logic [511:0] w;
    logic [TW-1:0] t;
    logic signed [11:0] el;
    w = mem[a];
    t = '0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        el = w[(i*6+j)*12 +: 12];
        t[(i*6+j)*12 +: 12] = el;
      end
    return t;
  endfunction

  task automatic run_job(input string nm, input logic s, input int base, input int count,
                         input int total, input int idv, input int stall_at, input int stall_len,
                         output int tiles, output int dones);
    int n, skew, exp_od, endv, c, stop;
    bit active;
    exp_t e;
    n = s ? 4 : 2; skew = s ? 2 : 1;
    endv = base + count; exp_od = base; active = (count > 0);
    tiles = 0; dones = 0; stop = -1;
    for (int k = 0; k < 4; k++) sb[k].delete();
    sel = s;
    @(negedge clk);
    total_od = 8'(total); id = 4'(idv); od_base = 8'(base); od_count = 8'(count);
    if (s) start4 = 1'b1; else start2 = 1'b1;
    for (c = 0; c < 300 && c != stop; c++) begin
      @(posedge clk); #1;
      start2 = 1'b0; start4 = 1'b0;
      pe_ready = !(c >= stall_at && c < stall_at + stall_len);
      @(negedge clk);
      for (int k = 0; k < n; k++) begin
        logic exp_req;
        logic [7:0] ea;
        exp_req = active && pe_ready && (exp_od + k < endv);
        ea = 8'((exp_od + k) + total * idv);
        checks++;
        if (v_req[k] !== exp_req) begin
          errors++; $display("FAIL %s req lane%0d c%0d: got %b want %b", nm, k, c, v_req[k], exp_req);
        end
        if (exp_req) begin
          checks++;
          if (v_addr[k] !== ea) begin
            errors++; $display("FAIL %s addr lane%0d c%0d: got %0d want %0d", nm, k, c, v_addr[k], ea);
          end
          e.tag = 8'(exp_od + k); e.addr = ea; e.due = c + 2 + k * skew;
          sb[k].push_back(e);
        end
      end
      if (active && pe_ready) begin
        exp_od += n;
        if (exp_od >= endv) active = 0;
      end
      for (int k = 0; k < n; k++) begin
        if (v_tv[k]) begin
          tiles++;
          checks++;
          if (sb[k].size() == 0) begin
            errors++; $display("FAIL %s unexpected_valid lane%0d c%0d: got 1 want 0", nm, k, c);
          end else begin
            e = sb[k].pop_front();
            checks++;
            if (v_od[k] !== e.tag) begin
              errors++; $display("FAIL %s tag lane%0d: got %0d want %0d", nm, k, v_od[k], e.tag);
            end
            checks++;
            if (v_tile[k] !== ref_tile(e.addr)) begin
              errors++; $display("FAIL %s tile lane%0d: got %h want %h", nm, k, v_tile[k], ref_tile(e.addr));
            end
            checks++;
            if (c !== e.due) begin
              errors++; $display("FAIL %s valid_time lane%0d: got c%0d want c%0d", nm, k, c, e.due);
            end
          end
        end
      end
      if (v_done) begin
        int pend;
        dones++;
        pend = 0;
        for (int k = 0; k < 4; k++) pend += sb[k].size();
        checks++;
        if (pend != 0 || v_busy !== 1'b1) begin
          errors++; $display("FAIL %s done_state: got pending=%0d busy=%b want 0/1", nm, pend, v_busy);
        end
        if (stop < 0) stop = c + 4;
      end
    end
    checks++;
    if (dones == 0) begin
      errors++; $display("FAIL %s timeout: got no done want done", nm);
    end
    checks++;
    if (v_busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_after: got %b want 0", nm, v_busy);
    end
  endtask

  task automatic check_tiles(input string nm, input int tiles, input int dones, input int want);
    checks++;
    if (tiles != want || dones != 1) begin
      errors++; $display("FAIL %s counts: got tiles=%0d dones=%0d want %0d/1", nm, tiles, dones, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy2, done2, req2, tv2, busy4, done4, req4, tv4} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {busy2, done2, req2, tv2, busy4, done4, req4, tv4});
    end
    checks++;
    if (tile2 !== '0 || od2 !== '0 || tile4 !== '0 || od4 !== '0) begin
      errors++; $display("FAIL reset_data: got nonzero tile/od want 0");
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int t, d;
    run_job("basic", 1'b0, 4, 4, 16, 2, 1000, 0, t, d);
    check_tiles("basic", t, d, 4);
  endtask

  task automatic test_partial_group();
    int t, d;
    run_job("partial", 1'b0, 4, 3, 16, 2, 1000, 0, t, d);
    check_tiles("partial", t, d, 3);
  endtask

  task automatic test_stall();
    int t, d;
    run_job("stall", 1'b0, 4, 8, 16, 2, 1, 5, t, d);
    check_tiles("stall", t, d, 8);
  endtask

  task automatic test_addr_wrap();
    int t, d;
    run_job("wrap", 1'b0, 100, 2, 200, 2, 1000, 0, t, d);
    check_tiles("wrap", t, d, 2);
  endtask

  task automatic test_zero_count();
    int t, d;
    run_job("zero", 1'b0, 9, 0, 16, 1, 1000, 0, t, d);
    check_tiles("zero", t, d, 0);
  endtask

  task automatic test_reset_in_drain();
    int t, d, seen;
    sel = 1'b0;
    @(negedge clk);
    total_od = 8'd16; id = 4'd2; od_base = 8'd4; od_count = 8'd4; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0; pe_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b1 || done2 !== 1'b0) begin
      errors++; $display("FAIL rst_drain_pre: got busy=%b done=%b want 1/0", busy2, done2);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy2, done2, req2, tv2} !== '0 || tile2 !== '0 || od2 !== '0) begin
      errors++; $display("FAIL rst_drain_outputs: got busy=%b done=%b req=%b tv=%b want 0", busy2, done2, req2, tv2);
    end
    seen = 0;
    repeat (2) begin @(negedge clk); seen += done2; end
    reset = 1'b1;
    repeat (3) begin @(negedge clk); seen += done2; end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rst_drain_done: got %0d pulses want 0", seen);
    end
    run_job("after_rst", 1'b0, 4, 4, 16, 2, 1000, 0, t, d);
    check_tiles("after_rst", t, d, 4);
  endtask

  task automatic test_stray_valid();
    int t, d;
    sel = 1'b0;
    @(posedge clk); #1 inj2 = 2'b01;
    @(posedge clk); #1 inj2 = 2'b00;
    @(negedge clk);
    checks++;
    if (tv2 !== 2'b01 || busy2 !== 1'b0) begin
      errors++; $display("FAIL stray_forward: got tv=%b busy=%b want 01/0", tv2, busy2);
    end
    repeat (2) @(negedge clk);
    run_job("post_stray", 1'b0, 10, 4, 16, 3, 1000, 0, t, d);
    check_tiles("post_stray", t, d, 4);
  endtask

  task automatic test_four_lane();
    int t, d;
    run_job("lanes4", 1'b1, 3, 8, 50, 3, 1000, 0, t, d);
    check_tiles("lanes4", t, d, 8);
    sel = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++)
      for (int w = 0; w < 16; w++) mem[a][w*32 +: 32] = $urandom;
    start2 = 1'b0; start4 = 1'b0; pe_ready = 1'b1; inj2 = 2'b00; sel = 1'b0;
    total_od = '0; od_base = '0; od_count = '0; id = '0;
    test_reset();
    test_basic();
    test_partial_group();
    test_stall();
    test_addr_wrap();
    test_zero_count();
    test_reset_in_drain();
    test_stray_valid();
    test_four_lane();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
